// File: rtl/cl_bank_sched.sv
// ---------------------------------------------------------------------------
// cl_bank_sched
//   Frame/line sequencer for the Camera Link capture path. Produces the row
//   address, line-bitmap clear pulse and per-bank write strobes for an A/B
//   ping-pong frame store. It also arbitrates the two banks between the
//   capture writer and a single downstream reader. The writer always owns one
//   bank, and the reader is handed the most recently completed frame.
//
// Parameters
//   ADDR_WIDTH  width of the row address / row counter
//   MAX_ROWS    rows stored per frame; lines beyond this are not written
//   CNT_WIDTH   statistics counter width (exists only with CL_BANK_STATS_EN)
//
// Ports
//   CCLK        camera pixel clock, rising edge
//   RST         synchronous active-high reset
//   iVSYNC      frame valid from the CL receiver
//   iDE         line valid from the CL receiver
//   iRD_REQ     reader requests a completed frame (level)
//   iRD_DONE    reader releases its granted bank (1-cycle pulse)
//   oWR_ROW     row address for the line being written
//   oCLR        1-cycle pulse, clear line bitmap before the line starts
//   oWEA/oWEB   1-cycle write strobes for bank A / bank B
//   oRD_GNT     level, reader owns bank oRD_SEL
//   oRD_SEL     bank granted to the reader (0=A, 1=B)
//   oFRAME_RDY  level, a completed and ungranted frame is waiting
//   oDROP       1-cycle pulse, a completed frame was discarded
//   oOVF        sticky per frame, line count exceeded MAX_ROWS
//
// Build option
//   CL_BANK_STATS_EN : adds oFRAME_CNT (commits) and oDROP_CNT (drops),
//                      both CNT_WIDTH bits wide and wrapping.
// ---------------------------------------------------------------------------
module cl_bank_sched #(
  parameter int ADDR_WIDTH = 11,
  parameter int MAX_ROWS   = 480
`ifdef CL_BANK_STATS_EN
  ,
  parameter int CNT_WIDTH  = 16
`endif
) (
  input  logic                  CCLK,
  input  logic                  RST,
  input  logic                  iVSYNC,
  input  logic                  iDE,
  input  logic                  iRD_REQ,
  input  logic                  iRD_DONE,
  output logic [ADDR_WIDTH-1:0] oWR_ROW,
  output logic                  oCLR,
  output logic                  oWEA,
  output logic                  oWEB,
  output logic                  oRD_GNT,
  output logic                  oRD_SEL,
  output logic                  oFRAME_RDY,
  output logic                  oDROP,
  output logic                  oOVF
`ifdef CL_BANK_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  oFRAME_CNT,
  output logic [CNT_WIDTH-1:0]  oDROP_CNT
`endif
);

  localparam logic [ADDR_WIDTH-1:0] ROW_LIMIT = ADDR_WIDTH'(MAX_ROWS);

  typedef enum logic [1:0] {
    W_IDLE,
    W_FRAME,
    W_COMMIT
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_GRANT
  } rd_state_t;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic vs_q, vs_qq;
  logic de_q, de_qq;
  logic wr_bank;
  logic ready;

  logic vs_rise, vs_fall, de_rise, de_fall;
  logic frame_start, line_start, line_end, line_fits;
  logic commit, drop_now, grant_take, grant_release;

  // Input sampling. The VSYNC pair resets to "high" so that a frame already
  // in progress when reset is released cannot look like a fresh rise; the
  // writer only restarts after VSYNC has been seen low and then high again.
  always_ff @(posedge CCLK) begin
    if (RST) begin
      vs_q  <= 1'b1;
      vs_qq <= 1'b1;
      de_q  <= 1'b0;
      de_qq <= 1'b0;
    end else begin
      vs_q  <= iVSYNC;
      vs_qq <= vs_q;
      de_q  <= iDE;
      de_qq <= de_q;
    end
  end

  // Edge decode and event qualification. A VSYNC fall takes priority over
  // any DE edge in the same cycle, so a line cut short by end-of-frame never
  // produces a clear or a write strobe.
  always_comb begin
    vs_rise       = vs_q & ~vs_qq;
    vs_fall       = ~vs_q & vs_qq;
    de_rise       = de_q & ~de_qq;
    de_fall       = ~de_q & de_qq;
    frame_start   = (wr_state == W_IDLE) && vs_rise;
    line_start    = (wr_state == W_FRAME) && de_rise && !vs_fall;
    line_end      = (wr_state == W_FRAME) && de_fall && !vs_fall;
    line_fits     = (oWR_ROW < ROW_LIMIT);
    commit        = (wr_state == W_COMMIT);
    drop_now      = commit && ((rd_state == R_GRANT) || ready);
    grant_take    = (rd_state == R_IDLE) && iRD_REQ && ready && !commit;
    grant_release = (rd_state == R_GRANT) && iRD_DONE;
  end

  // Writer FSM
  always_ff @(posedge CCLK) begin
    if (RST) begin
      wr_state <= W_IDLE;
    end else begin
      wr_state <= wr_next;
    end
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE:   if (vs_rise) wr_next = W_FRAME;
      W_FRAME:  if (vs_fall) wr_next = W_COMMIT;
      W_COMMIT: wr_next = W_IDLE;
      default:  wr_next = W_IDLE;
    endcase
  end

  // Reader FSM
  always_ff @(posedge CCLK) begin
    if (RST) begin
      rd_state <= R_IDLE;
    end else begin
      rd_state <= rd_next;
    end
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (grant_take) rd_next = R_GRANT;
      R_GRANT: if (grant_release) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  // Line sequencing: strobes are registered, the row advances on the cycle
  // after its strobe so the strobe and its row address are seen together.
  always_ff @(posedge CCLK) begin
    if (RST) begin
      oWR_ROW <= '0;
      oCLR    <= 1'b0;
      oWEA    <= 1'b0;
      oWEB    <= 1'b0;
      oOVF    <= 1'b0;
    end else begin
      oCLR <= line_start;
      oWEA <= line_end && line_fits && !wr_bank;
      oWEB <= line_end && line_fits && wr_bank;
      if (frame_start) begin
        oWR_ROW <= '0;
        oOVF    <= 1'b0;
      end else begin
        if (oWEA || oWEB) begin
          oWR_ROW <= oWR_ROW + ADDR_WIDTH'(1);
        end
        if (line_end && !line_fits) begin
          oOVF <= 1'b1;
        end
      end
    end
  end

  // Bank ownership. A commit with an idle reader publishes the new frame by
  // swapping banks; with the reader busy the new frame is thrown away and
  // the writer keeps overwriting the same bank.
  always_ff @(posedge CCLK) begin
    if (RST) begin
      wr_bank <= 1'b0;
      ready   <= 1'b0;
      oDROP   <= 1'b0;
      oRD_SEL <= 1'b0;
      oRD_GNT <= 1'b0;
    end else begin
      oDROP   <= drop_now;
      oRD_GNT <= (rd_next == R_GRANT);
      if (commit && (rd_state == R_IDLE)) begin
        wr_bank <= ~wr_bank;
        ready   <= 1'b1;
      end else if (grant_take) begin
        ready <= 1'b0;
      end
      if (grant_take) begin
        oRD_SEL <= ~wr_bank;
      end
    end
  end

  assign oFRAME_RDY = ready;

`ifdef CL_BANK_STATS_EN
  always_ff @(posedge CCLK) begin
    if (RST) begin
      oFRAME_CNT <= '0;
      oDROP_CNT  <= '0;
    end else begin
      if (commit) begin
        oFRAME_CNT <= oFRAME_CNT + CNT_WIDTH'(1);
      end
      if (drop_now) begin
        oDROP_CNT <= oDROP_CNT + CNT_WIDTH'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_cl_bank_sched.sv
// ---------------------------------------------------------------------------
// tb_cl_bank_sched
//   Self-checking bench for cl_bank_sched (MAX_ROWS reduced to 4 so overflow
//   is reachable quickly). A hand-computed vector table covers the first
//   frames, short hand sequences cover drop/overflow/reset, and a randomized
//   run is compared every cycle against a frame-level reference model.
// ---------------------------------------------------------------------------
module tb_cl_bank_sched;

  localparam int AW = 11;
  localparam int MR = 4;
  localparam int OW = AW + 8;

  logic          CCLK = 1'b0;
  logic          RST = 1'b1;
  logic          iVSYNC = 1'b0;
  logic          iDE = 1'b0;
  logic          iRD_REQ = 1'b0;
  logic          iRD_DONE = 1'b0;
  logic [AW-1:0] oWR_ROW;
  logic          oCLR, oWEA, oWEB, oRD_GNT, oRD_SEL, oFRAME_RDY, oDROP, oOVF;
`ifdef CL_BANK_STATS_EN
  logic [15:0]   oFRAME_CNT, oDROP_CNT;
`endif

  always #5 CCLK = ~CCLK;

  cl_bank_sched #(
    .ADDR_WIDTH(AW),
    .MAX_ROWS  (MR)
  ) dut (
    .CCLK      (CCLK),
    .RST       (RST),
    .iVSYNC    (iVSYNC),
    .iDE       (iDE),
    .iRD_REQ   (iRD_REQ),
    .iRD_DONE  (iRD_DONE),
    .oWR_ROW   (oWR_ROW),
    .oCLR      (oCLR),
    .oWEA      (oWEA),
    .oWEB      (oWEB),
    .oRD_GNT   (oRD_GNT),
    .oRD_SEL   (oRD_SEL),
    .oFRAME_RDY(oFRAME_RDY),
    .oDROP     (oDROP),
    .oOVF      (oOVF)
`ifdef CL_BANK_STATS_EN
    ,
    .oFRAME_CNT(oFRAME_CNT),
    .oDROP_CNT (oDROP_CNT)
`endif
  );

  logic [OW-1:0] dut_out;
  assign dut_out = {oWR_ROW, oCLR, oWEA, oWEB, oRD_GNT, oRD_SEL, oFRAME_RDY, oDROP, oOVF};

  int total = 0;
  int bad = 0;
  int cyc_n = 0;
  int cnt_wea, cnt_web, cnt_drop, cnt_clr;

  // Reference model: frame-level view of the sequencer
  bit h_vs1, h_vs2, h_de1, h_de2;   // last two sampled input levels
  bit m_in_frame, m_commit_due;
  int m_row, m_wbank, m_rd_bank, m_frames, m_drops;
  bit m_ovf, m_ready, m_rd_busy;
  bit m_clr, m_wea, m_web, m_drop;

  function automatic logic [OW-1:0] pack(int row, bit clr, bit wea, bit web, bit gnt,
                                         bit sel, bit rdy, bit drop, bit ovf);
    logic [AW-1:0] r;
    r = AW'(row);
    return {r, clr, wea, web, gnt, sel, rdy, drop, ovf};
  endfunction

  function automatic logic [OW-1:0] model_out();
    return pack(m_row, m_clr, m_wea, m_web, m_rd_busy, m_rd_bank[0], m_ready, m_drop, m_ovf);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc_n, act, exp);
    end
  endtask

  task automatic model_reset();
    h_vs1 = 1'b1; h_vs2 = 1'b1; h_de1 = 1'b0; h_de2 = 1'b0;
    m_in_frame = 1'b0; m_commit_due = 1'b0;
    m_row = 0; m_wbank = 0; m_rd_bank = 0; m_frames = 0; m_drops = 0;
    m_ovf = 1'b0; m_ready = 1'b0; m_rd_busy = 1'b0;
    m_clr = 1'b0; m_wea = 1'b0; m_web = 1'b0; m_drop = 1'b0;
  endtask

  task automatic model_step(input bit rst, input bit vs, input bit de, input bit req, input bit done);
    bit vr, vf, dr, df, was_commit, stb_prev;
    if (rst) begin
      model_reset();
      return;
    end
    vr = h_vs1 && !h_vs2;
    vf = !h_vs1 && h_vs2;
    dr = h_de1 && !h_de2;
    df = !h_de1 && h_de2;
    was_commit = m_commit_due;
    stb_prev = m_wea || m_web;
    m_clr = 1'b0; m_wea = 1'b0; m_web = 1'b0; m_drop = 1'b0;
    if (stb_prev) m_row++;
    if (was_commit) begin
      m_commit_due = 1'b0;
      m_frames++;
      if (m_rd_busy) begin
        m_drop = 1'b1;           // reader holds the old frame: new one is lost
      end else begin
        m_drop = m_ready;        // an unread frame is replaced by the new one
        m_ready = 1'b1;
        m_wbank = 1 - m_wbank;
      end
      if (m_drop) m_drops++;
    end else if (m_in_frame) begin
      if (vf) begin
        m_in_frame = 1'b0;
        m_commit_due = 1'b1;
      end else begin
        m_clr = dr;
        if (df) begin
          if (m_row < MR) begin
            if (m_wbank == 0) m_wea = 1'b1;
            else m_web = 1'b1;
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
    end else if (vr) begin
      m_in_frame = 1'b1;
      m_row = 0;
      m_ovf = 1'b0;
    end
    if (m_rd_busy) begin
      if (done) m_rd_busy = 1'b0;
    end else if (req && m_ready && !was_commit) begin
      m_rd_busy = 1'b1;
      m_rd_bank = 1 - m_wbank;
      m_ready = 1'b0;
    end
    h_vs2 = h_vs1; h_vs1 = vs;
    h_de2 = h_de1; h_de1 = de;
  endtask

  // One clock: drive at negedge, sample #1 after the rising edge.
  task automatic cyc(input bit rst, input bit vs, input bit de, input bit req, input bit done);
    @(negedge CCLK);
    RST = rst; iVSYNC = vs; iDE = de; iRD_REQ = req; iRD_DONE = done;
    model_step(rst, vs, de, req, done);
    @(posedge CCLK);
    #1;
    cyc_n++;
    chk("model", 32'(dut_out), 32'(model_out()));
`ifdef CL_BANK_STATS_EN
    chk("frame_cnt", 32'(oFRAME_CNT), 32'(m_frames[15:0]));
    chk("drop_cnt", 32'(oDROP_CNT), 32'(m_drops[15:0]));
`endif
    cnt_wea += int'(oWEA);
    cnt_web += int'(oWEB);
    cnt_drop += int'(oDROP);
    cnt_clr += int'(oCLR);
  endtask

  task automatic clear_counts();
    cnt_wea = 0; cnt_web = 0; cnt_drop = 0; cnt_clr = 0;
  endtask

  // Frame of n lines (2 high / 2 low each); returns per-line overflow snapshot.
  task automatic line_frame(input int n, output logic [7:0] ovf_mask);
    ovf_mask = '0;
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < n; i++) begin
      cyc(0, 1, 1, 0, 0);
      cyc(0, 1, 1, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      ovf_mask[i] = oOVF;
    end
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit rst, vs, de, req, done;
    int row;
    bit clr, wea, web, gnt, sel, rdy, drop, ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit vs, bit de, bit req, bit done, int row,
                              bit clr, bit wea, bit web, bit gnt, bit rdy, bit drop);
    vec_t v;
    v.rst = rst; v.vs = vs; v.de = de; v.req = req; v.done = done;
    v.row = row; v.clr = clr; v.wea = wea; v.web = web; v.gnt = gnt;
    v.sel = 1'b0; v.rdy = rdy; v.drop = drop; v.ovf = 1'b0;
    return v;
  endfunction

  initial begin
    logic [7:0] om;
    bit rreq, rdone, rrst;
    model_reset();
    clear_counts();

    //            rst vs de rq dn row clr wea web gnt rdy drop
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 2, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 3, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 3, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].rst, tbl[i].vs, tbl[i].de, tbl[i].req, tbl[i].done);
      chk("table", 32'(dut_out),
          32'(pack(tbl[i].row, tbl[i].clr, tbl[i].wea, tbl[i].web, tbl[i].gnt,
                   tbl[i].sel, tbl[i].rdy, tbl[i].drop, tbl[i].ovf)));
    end

    // Two unread frames in a row: each commit overwrites the waiting frame.
    clear_counts();
    line_frame(2, om);
    line_frame(2, om);
    chk("stale_wea", 32'(cnt_wea), 32'd2);
    chk("stale_web", 32'(cnt_web), 32'd2);
    chk("stale_drops", 32'(cnt_drop), 32'd2);
    chk("stale_rdy", 32'(oFRAME_RDY), 32'd1);
    cyc(0, 0, 0, 1, 0);
    chk("newest_gnt", 32'(oRD_GNT), 32'd1);
    chk("newest_sel", 32'(oRD_SEL), 32'd1);
    cyc(0, 0, 0, 0, 1);
    chk("release_gnt", 32'(oRD_GNT), 32'd0);

    // Overflow: 6 lines into a 4-row store.
    clear_counts();
    line_frame(6, om);
    chk("ovf_strobes", 32'(cnt_wea + cnt_web), 32'd4);
    chk("ovf_lines", 32'(om[5:0]), 32'h30);
    chk("ovf_row_sat", 32'(oWR_ROW), 32'd4);
    chk("ovf_sticky", 32'(oOVF), 32'd1);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("ovf_cleared", 32'(oOVF), 32'd0);
    chk("row_restart", 32'(oWR_ROW), 32'd0);

    // Reset in the middle of a line, then VSYNC stays high.
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    chk("rst_outputs", 32'(dut_out), 32'd0);
`ifdef CL_BANK_STATS_EN
    chk("rst_counters", 32'({oFRAME_CNT, oDROP_CNT}), 32'd0);
`endif
    clear_counts();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
    end
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("rst_no_strobe", 32'(cnt_wea + cnt_web + cnt_clr), 32'd0);
    line_frame(1, om);
    chk("rst_resume_wea", 32'(cnt_wea), 32'd1);

    // Randomized frames against the model.
    for (int f = 0; f < 60; f++) begin
      int gap, nl;
      gap = int'($urandom_range(1, 4));
      nl = int'($urandom_range(0, 7));
      for (int g = 0; g < gap; g++) begin
        rreq = ($urandom % 3) == 0; rdone = ($urandom % 5) == 0; rrst = ($urandom % 200) == 0;
        cyc(rrst, 0, 0, rreq, rdone);
      end
      for (int l = 0; l < nl; l++) begin
        int hi, lo;
        hi = int'($urandom_range(1, 3));
        lo = int'($urandom_range(1, 3));
        for (int k = 0; k < hi; k++) begin
          rreq = ($urandom % 3) == 0; rdone = ($urandom % 5) == 0; rrst = ($urandom % 200) == 0;
          cyc(rrst, 1, 1, rreq, rdone);
        end
        if (($urandom % 10) == 0) break;   // VSYNC drops with DE still high
        for (int k = 0; k < lo; k++) begin
          rreq = ($urandom % 3) == 0; rdone = ($urandom % 5) == 0; rrst = ($urandom % 200) == 0;
          cyc(rrst, 1, 0, rreq, rdone);
        end
      end
    end
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
